// File: rtl/debug_prog_loader.sv
// Debug-unit program loader: pops LOAD cmd, size byte and little-endian instruction bytes from the UART RX FIFO,
// writes each assembled instruction to consecutive instruction-memory addresses, then pushes ACK (or NACK) to UART TX.
// Ports: RX FIFO pop side (i_rx_empty/i_rx_data/o_rd_uart), TX FIFO push side (i_tx_full/o_wr_uart/o_tx_data),
//        instruction-memory write port (o_mem_w/o_mem_addr/o_inst), status (o_prog_sz/o_busy/o_loaded/o_err).
module debug_prog_loader #(
    parameter int                DATA_W    = 8,
    parameter int                INST_SZ   = 32,
    parameter int                ADDR_W    = 5,
    parameter logic [DATA_W-1:0] CMD_LOAD  = 8'hFE,
    parameter logic [DATA_W-1:0] ACK_BYTE  = 8'hAA,
    parameter logic [DATA_W-1:0] NACK_BYTE = 8'hEE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [DATA_W-1:0]  i_rx_data,
    output logic               o_rd_uart,
    input  logic               i_tx_full,
    output logic               o_wr_uart,
    output logic [DATA_W-1:0]  o_tx_data,
    output logic               o_mem_w,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [INST_SZ-1:0] o_inst,
    output logic [7:0]         o_prog_sz,
    output logic               o_busy,
    output logic               o_loaded,
    output logic               o_err
);

    localparam int LANES = INST_SZ / DATA_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    // Wide enough to hold 2^ADDR_W and any size byte without overflow.
    localparam int CMP_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
    localparam logic [CMP_W-1:0] DEPTH = CMP_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {IDLE, SIZE, BYTE, WRITE, ACK, NACK} state_t;

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic             consume;
    logic [CMP_W-1:0] written;
    logic [CMP_W-1:0] size_in;

    assign consume = (state == IDLE) || (state == SIZE) || (state == BYTE);
    // The pop strobe has to be combinational so the FIFO head byte can be
    // consumed on every cycle; gating with reset keeps it low while in reset.
    assign o_rd_uart = i_reset && consume && !i_rx_empty;
    // Instructions written once the current WRITE cycle completes.
    assign written = CMP_W'(o_mem_addr) + CMP_W'(1);
    assign size_in = CMP_W'(i_rx_data);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            o_wr_uart  <= 1'b0;
            o_tx_data  <= '0;
            o_mem_w    <= 1'b0;
            o_mem_addr <= '0;
            o_inst     <= '0;
            o_prog_sz  <= '0;
            o_busy     <= 1'b0;
            o_loaded   <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_mem_w <= 1'b0;
            case (state)
                IDLE: begin
                    if (o_rd_uart && i_rx_data == CMD_LOAD) begin
                        state    <= SIZE;
                        o_busy   <= 1'b1;
                        o_err    <= 1'b0;
                        o_loaded <= 1'b0;
                    end
                end
                SIZE: begin
                    if (o_rd_uart) begin
                        o_prog_sz <= 8'(i_rx_data);
                        if (size_in == '0) begin
                            // Empty program: acknowledge straight away.
                            state     <= ACK;
                            o_tx_data <= ACK_BYTE;
                            o_wr_uart <= !i_tx_full;
                        end else if (size_in > DEPTH) begin
                            state     <= NACK;
                            o_err     <= 1'b1;
                            o_tx_data <= NACK_BYTE;
                            o_wr_uart <= !i_tx_full;
                        end else begin
                            state      <= BYTE;
                            o_mem_addr <= '0;
                            byte_cnt   <= '0;
                            o_inst     <= '0;
                        end
                    end
                end
                BYTE: begin
                    if (o_rd_uart) begin
                        o_inst[int'(byte_cnt) * DATA_W +: DATA_W] <= i_rx_data;
                        if (byte_cnt == CNT_W'(LANES - 1)) begin
                            state   <= WRITE;
                            o_mem_w <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // Address may wrap to 0 after a full-depth load; harmless.
                    o_mem_addr <= o_mem_addr + 1'b1;
                    byte_cnt   <= '0;
                    o_inst     <= '0;
                    if (written == CMP_W'(o_prog_sz)) begin
                        state     <= ACK;
                        o_tx_data <= ACK_BYTE;
                        o_wr_uart <= !i_tx_full;
                    end else begin
                        state <= BYTE;
                    end
                end
                ACK, NACK: begin
                    // o_wr_uart may already have been raised on entry when TX
                    // had room; otherwise raise it once TX drains.
                    if (o_wr_uart) begin
                        o_wr_uart <= 1'b0;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                        if (state == ACK) begin
                            o_loaded <= 1'b1;
                        end
                    end else if (!i_tx_full) begin
                        o_wr_uart <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_prog_loader.sv
module tb_debug_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_empty;
    logic [7:0]  rx_data;
    logic        rd;
    logic        tx_full;
    logic        wr;
    logic [7:0]  tx_data;
    logic        mem_w;
    logic [4:0]  mem_addr;
    logic [31:0] inst;
    logic [7:0]  prog_sz;
    logic        busy;
    logic        loaded;
    logic        err;

    always #5 clk = ~clk;

    debug_prog_loader dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_rx_empty(rx_empty), .i_rx_data(rx_data), .o_rd_uart(rd),
        .i_tx_full(tx_full), .o_wr_uart(wr), .o_tx_data(tx_data),
        .o_mem_w(mem_w), .o_mem_addr(mem_addr), .o_inst(inst),
        .o_prog_sz(prog_sz), .o_busy(busy), .o_loaded(loaded), .o_err(err)
    );

    logic [7:0]  rx_q[$];
    logic [36:0] obs_w[$], exp_w[$];
    logic [7:0]  obs_tx[$], exp_tx[$];
    int          obs_wc[$], tx_cyc[$], pop_cyc[$];
    int          cyc, checks, failures, viol, free_cyc, tx_full_cnt, stall_mode;
    logic        stall;
    bit          tx_rand;
    bit          m_loaded, m_err;
    logic [7:0]  m_psz;

    task automatic drive();
        rx_empty = (rx_q.size() == 0) || stall;
        rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    // One clock: observe at the falling edge, update the RX/TX FIFO models after the rising edge.
    task automatic cycle();
        logic popped;
        @(negedge clk);
        cyc++;
        if (rd && rx_empty) viol++;
        popped = rd;
        if (rd) pop_cyc.push_back(cyc);
        if (mem_w) begin obs_w.push_back({mem_addr, inst}); obs_wc.push_back(cyc); end
        if (wr) begin obs_tx.push_back(tx_data); tx_cyc.push_back(cyc); end
        @(posedge clk);
        #1;
        if (popped && rx_q.size() > 0) void'(rx_q.pop_front());
        case (stall_mode)
            1:       stall = ~stall;
            2:       stall = ($urandom % 3 == 0);
            default: stall = 1'b0;
        endcase
        if (tx_full_cnt > 0) begin
            tx_full_cnt--;
            if (tx_full_cnt == 0) begin tx_full = 1'b0; free_cyc = cyc + 1; end
        end else if (tx_rand) begin
            tx_full = ($urandom % 3 == 0);
        end
        drive();
    endtask

    task automatic clear_sb();
        obs_w.delete(); exp_w.delete(); obs_tx.delete(); exp_tx.delete();
        obs_wc.delete(); tx_cyc.delete(); pop_cyc.delete(); viol = 0;
    endtask

    // Reference: parse the byte stream by the protocol rules, producing the expected writes, TX bytes and status.
    task automatic model(input logic [7:0] s[$]);
        int n, i;
        logic [7:0] sz;
        bit done;
        n = s.size();
        i = 0;
        while (i < n) begin
            if (s[i] == 8'hFE) begin
                m_loaded = 0; m_err = 0; i++;
                if (i < n) begin
                    sz = s[i]; i++; m_psz = sz;
                    if (sz == 0) begin
                        exp_tx.push_back(8'hAA); m_loaded = 1;
                    end else if (sz > 32) begin
                        exp_tx.push_back(8'hEE); m_err = 1;
                    end else begin
                        done = 1;
                        for (int k = 0; k < int'(sz); k++) begin
                            if (i + 4 > n) begin done = 0; i = n; break; end
                            exp_w.push_back({5'(k), s[i+3], s[i+2], s[i+1], s[i]});
                            i += 4;
                        end
                        if (done) begin exp_tx.push_back(8'hAA); m_loaded = 1; end
                    end
                end
            end else begin
                i++;
            end
        end
    endtask

    task automatic send(input logic [7:0] s[$]);
        model(s);
        foreach (s[k]) rx_q.push_back(s[k]);
        drive();
    endtask

    task automatic feed(input logic [127:0] v, input int n);
        logic [7:0] s[$];
        for (int k = 0; k < n; k++) s.push_back(v[8*(n-1-k) +: 8]);
        send(s);
    endtask

    function automatic int w_errs();
        int e, m;
        m = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
        e = (obs_w.size() > exp_w.size()) ? obs_w.size() - exp_w.size() : exp_w.size() - obs_w.size();
        for (int i = 0; i < m; i++) if (obs_w[i] !== exp_w[i]) e++;
        return e;
    endfunction

    function automatic int tx_errs();
        int e, m;
        m = (obs_tx.size() < exp_tx.size()) ? obs_tx.size() : exp_tx.size();
        e = (obs_tx.size() > exp_tx.size()) ? obs_tx.size() - exp_tx.size() : exp_tx.size() - obs_tx.size();
        for (int i = 0; i < m; i++) if (obs_tx[i] !== exp_tx[i]) e++;
        return e;
    endfunction

    task automatic run_idle(input int max, output bit ok);
        int quiet;
        quiet = 0;
        ok = 0;
        for (int i = 0; i < max; i++) begin
            cycle();
            if (rx_q.size() == 0 && !busy) quiet++; else quiet = 0;
            if (quiet >= 3) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rx_q.push_back(8'h12); drive();
        repeat (3) cycle();
        checks++;
        if ({rd, wr, tx_data, mem_w, mem_addr, inst, prog_sz, busy, loaded, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rd=%b wr=%b tx=%h w=%b a=%0d inst=%h sz=%0d busy=%b ld=%b err=%b, expected all 0",
                     rd, wr, tx_data, mem_w, mem_addr, inst, prog_sz, busy, loaded, err);
        end
        rst_n = 1'b1;
        clear_sb();
        m_loaded = 0; m_err = 0; m_psz = 0;
        run_idle(50, ok);
        checks++;
        if (!ok || pop_cyc.size() != 1 || obs_w.size() != 0 || obs_tx.size() != 0 || loaded !== 1'b0) begin
            failures++;
            $display("FAIL reset_junk: ok=%0b pops=%0d writes=%0d tx=%0d loaded=%b, expected 1 pop, no writes/tx, loaded 0",
                     ok, pop_cyc.size(), obs_w.size(), obs_tx.size(), loaded);
        end
    endtask

    task automatic test_basic();
        bit ok;
        clear_sb();
        feed(128'hFE02030000000500000039000000, 14);
        run_idle(200, ok);
        checks++;
        if (!ok || w_errs() != 0) begin
            failures++;
            $display("FAIL basic_writes: ok=%0b got %0d writes (%0d mismatches), expected %0d", ok, obs_w.size(), w_errs(), exp_w.size());
        end
        checks++;
        if (tx_errs() != 0 || prog_sz !== 8'd2 || loaded !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_status: tx=%0d (%0d bad) sz=%0d loaded=%b err=%b, expected AA, 2, 1, 0",
                     obs_tx.size(), tx_errs(), prog_sz, loaded, err);
        end
        checks++;
        if (obs_wc.size() < 2 || pop_cyc.size() < 14 || tx_cyc.size() < 1 ||
            obs_wc[1] != pop_cyc[9] + 1 || tx_cyc[0] != obs_wc[1] + 1) begin
            failures++;
            $display("FAIL basic_latency: pops=%0d writes=%0d pushes=%0d, expected write 1 cycle after last payload pop and push 1 cycle later",
                     pop_cyc.size(), obs_wc.size(), tx_cyc.size());
        end
    endtask

    task automatic test_ignore_zero();
        bit ok;
        clear_sb();
        feed(128'h55FE00, 3);
        run_idle(100, ok);
        checks++;
        if (!ok || pop_cyc.size() != 3 || obs_w.size() != 0 || tx_errs() != 0 || loaded !== 1'b1 || prog_sz !== 8'd0) begin
            failures++;
            $display("FAIL zero_size: pops=%0d writes=%0d tx_bad=%0d loaded=%b sz=%0d, expected 3, 0, 0, 1, 0",
                     pop_cyc.size(), obs_w.size(), tx_errs(), loaded, prog_sz);
        end
    endtask

    task automatic test_nack();
        bit ok;
        clear_sb();
        feed(128'hFE21, 2);
        run_idle(100, ok);
        checks++;
        if (!ok || obs_w.size() != 0 || tx_errs() != 0 || err !== 1'b1 || loaded !== 1'b0 || prog_sz !== 8'h21) begin
            failures++;
            $display("FAIL nack: writes=%0d tx_bad=%0d err=%b loaded=%b sz=%h, expected 0, 0 (EE), 1, 0, 21",
                     obs_w.size(), tx_errs(), err, loaded, prog_sz);
        end
    endtask

    task automatic test_stall();
        bit ok;
        clear_sb();
        stall_mode = 1;
        tx_full = 1'b1;
        tx_full_cnt = 20;
        free_cyc = 0;
        feed(128'hFE0178563412, 6);
        run_idle(200, ok);
        stall_mode = 0;
        checks++;
        if (!ok || w_errs() != 0 || viol != 0) begin
            failures++;
            $display("FAIL stall_write: ok=%0b writes=%0d bad=%0d pop_on_empty=%0d, expected one write 12345678 at 0",
                     ok, obs_w.size(), w_errs(), viol);
        end
        checks++;
        if (tx_errs() != 0 || tx_cyc.size() != 1 || tx_cyc[0] < free_cyc || tx_cyc[0] > free_cyc + 1) begin
            failures++;
            $display("FAIL stall_ack: pushes=%0d at cycle %0d, expected one AA at cycle %0d..%0d",
                     tx_cyc.size(), (tx_cyc.size() != 0) ? tx_cyc[0] : -1, free_cyc, free_cyc + 1);
        end
    endtask

    task automatic test_reset_midload();
        bit ok;
        int guard;
        clear_sb();
        feed(128'hFE01AABBCCDD, 6);
        guard = 0;
        while (pop_cyc.size() < 4 && guard < 50) begin cycle(); guard++; end
        rst_n = 1'b0;
        #2;
        checks++;
        if (guard >= 50 || {rd, wr, tx_data, mem_w, mem_addr, inst, prog_sz, busy, loaded, err} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: guard=%0d busy=%b inst=%h sz=%0d loaded=%b, expected all outputs 0",
                     guard, busy, inst, prog_sz, loaded);
        end
        rx_q.delete(); drive();
        repeat (2) cycle();
        rst_n = 1'b1;
        clear_sb();
        m_loaded = 0; m_err = 0; m_psz = 0;
        feed(128'hFE01AABBCCDD, 6);
        run_idle(100, ok);
        checks++;
        if (!ok || w_errs() != 0 || obs_w.size() != 1 || obs_w[0] !== {5'd0, 32'hDDCCBBAA} || tx_errs() != 0 || loaded !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reload: ok=%0b writes=%0d bad=%0d tx_bad=%0d loaded=%b, expected DDCCBBAA at 0 then AA",
                     ok, obs_w.size(), w_errs(), tx_errs(), loaded);
        end
    endtask

    task automatic test_full_depth();
        bit ok;
        logic [7:0] s[$];
        clear_sb();
        s.push_back(8'hFE); s.push_back(8'h20);
        for (int k = 0; k < 128; k++) s.push_back(8'($urandom));
        send(s);
        run_idle(1000, ok);
        checks++;
        if (!ok || w_errs() != 0 || obs_w.size() != 32 || obs_w[31][36:32] !== 5'd31) begin
            failures++;
            $display("FAIL full_depth_writes: ok=%0b writes=%0d bad=%0d, expected 32 writes ending at addr 31",
                     ok, obs_w.size(), w_errs());
        end
        checks++;
        if (tx_errs() != 0 || busy !== 1'b0 || loaded !== 1'b1 || prog_sz !== 8'h20) begin
            failures++;
            $display("FAIL full_depth_status: tx_bad=%0d busy=%b loaded=%b sz=%0d, expected 0, 0, 1, 32",
                     tx_errs(), busy, loaded, prog_sz);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] s[$];
        logic [7:0] sz;
        int pick;
        stall_mode = 2;
        tx_rand = 1;
        for (int it = 0; it < 10; it++) begin
            clear_sb();
            s.delete();
            for (int j = $urandom_range(0, 2); j > 0; j--) s.push_back(8'($urandom_range(0, 253)));
            s.push_back(8'hFE);
            pick = $urandom_range(0, 9);
            sz = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd32 : (pick == 2) ? 8'd33 :
                 (pick == 3) ? 8'($urandom_range(34, 255)) : 8'($urandom_range(1, 8));
            s.push_back(sz);
            if (sz <= 32)
                for (int k = 0; k < 4 * int'(sz); k++)
                    s.push_back(($urandom % 8 == 0) ? 8'hFE : 8'($urandom));
            send(s);
            run_idle(2000, ok);
            checks++;
            if (!ok || w_errs() != 0 || viol != 0) begin
                failures++;
                $display("FAIL random_writes[%0d]: ok=%0b size=%0d writes=%0d bad=%0d pop_on_empty=%0d",
                         it, ok, sz, obs_w.size(), w_errs(), viol);
            end
            checks++;
            if (tx_errs() != 0 || prog_sz !== m_psz || loaded !== m_loaded || err !== m_err) begin
                failures++;
                $display("FAIL random_status[%0d]: tx_bad=%0d sz=%0d/%0d loaded=%b/%b err=%b/%b (got/expected)",
                         it, tx_errs(), prog_sz, m_psz, loaded, m_loaded, err, m_err);
            end
        end
        stall_mode = 0;
        tx_rand = 0;
        tx_full = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; viol = 0; free_cyc = 0;
        tx_full_cnt = 0; stall_mode = 0; stall = 1'b0; tx_rand = 0;
        rst_n = 1'b0;
        tx_full = 1'b0;
        drive();
        test_reset();
        test_basic();
        test_ignore_zero();
        test_nack();
        test_stall();
        test_reset_midload();
        test_full_depth();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
